// File: rtl/scoreboard_pkg.sv
// Shared ISA constants, field positions and types for the scoreboard issue controller.
package scoreboard_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int ALUOP_LSB  = 2;

  // Implicit registers used by jal (link) and setx/bex (status).
  localparam logic [4:0] REG_RA      = 5'd31;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       is_multi;
    logic       is_branch;
  } decode_t;

endpackage

// File: rtl/scoreboard_issue_ctrl_instr_decode.sv
// Combinational decode of one instruction into register fields and issue class.
module instr_decode
  import scoreboard_pkg::*;
(
  input  logic [31:0] instr_i,
  output decode_t     dec_o
);

  logic [4:0] opcode;
  logic [4:0] rd_f;
  logic [4:0] rs_f;
  logic [4:0] rt_f;
  logic [4:0] aluop;
  logic       unused_bits;

  assign opcode      = instr_i[OPCODE_LSB +: 5];
  assign rd_f        = instr_i[RD_LSB +: 5];
  assign rs_f        = instr_i[RS_LSB +: 5];
  assign rt_f        = instr_i[RT_LSB +: 5];
  assign aluop       = instr_i[ALUOP_LSB +: 5];
  assign unused_bits = ^{instr_i[11:7], instr_i[1:0]};

  always_comb begin
    dec_o = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_o.rd       = rd_f;
        dec_o.rs1      = rs_f;
        dec_o.rs2      = rt_f;
        dec_o.is_multi = (aluop == ALU_MUL) || (aluop == ALU_DIV);
      end
      OP_ADDI, OP_LW: begin
        dec_o.rd  = rd_f;
        dec_o.rs1 = rs_f;
      end
      // Stores and compare-branches read the rd field as a source.
      OP_SW: begin
        dec_o.rs1 = rd_f;
        dec_o.rs2 = rs_f;
      end
      OP_BNE, OP_BLT: begin
        dec_o.rs1       = rd_f;
        dec_o.rs2       = rs_f;
        dec_o.is_branch = 1'b1;
      end
      OP_J: dec_o.is_branch = 1'b1;
      OP_JAL: begin
        dec_o.rd        = REG_RA;
        dec_o.is_branch = 1'b1;
      end
      OP_JR: begin
        dec_o.rs1       = rd_f;
        dec_o.is_branch = 1'b1;
      end
      OP_BEX: begin
        dec_o.rs1       = REG_RSTATUS;
        dec_o.is_branch = 1'b1;
      end
      OP_SETX: dec_o.rd = REG_RSTATUS;
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/scoreboard_issue_ctrl.sv
// Issue/commit sequencer around the scoreboard: push from fetch, issue head to ALU or
// mult/div, arbitrate completions onto the single commit port, flush on branch redirect.
module scoreboard_issue_ctrl
  import scoreboard_pkg::*;
#(
  parameter int SB_SIZE = 32,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fetch_valid,
  input  logic [W-1:0] fetch_instr,
  input  logic [W-1:0] fetch_pc,
  output logic         fetch_ready,
  output logic         sb_push,
  output logic [W-1:0] sb_instr,
  output logic [W-1:0] sb_pc,
  output logic [4:0]   sb_rd,
  output logic [4:0]   sb_rs1,
  output logic [4:0]   sb_rs2,
  input  logic         sb_is_full,
  input  logic         sb_is_empty,
  input  logic [W-1:0] sb_head_instr,
  input  logic [W-1:0] sb_head_pc,
  input  logic         sb_head_ready,
  output logic         sb_start_head,
  output logic         sb_commit,
  output logic [W-1:0] sb_instr_to_finish,
  output logic         sb_flush,
  output logic [W-1:0] sb_instr_to_flush,
  output logic         alu_issue,
  output logic [W-1:0] alu_instr,
  output logic [W-1:0] alu_pc,
  input  logic         alu_redirect,
  output logic         md_start,
  output logic [W-1:0] md_instr,
  input  logic         md_done,
  output logic         md_ack,
  output logic         redirect
);

  localparam int unused_sb_size = SB_SIZE;

  logic         alu_v_q, alu_v_d;
  logic         alu_is_br_q, alu_is_br_d;
  logic [W-1:0] alu_instr_q, alu_instr_d;
  md_state_t    md_state_q, md_state_d;
  logic [W-1:0] md_instr_q, md_instr_d;

  decode_t fetch_dec;
  decode_t head_dec;
  logic    unused_dec;

  instr_decode u_fetch_dec (.instr_i(fetch_instr),   .dec_o(fetch_dec));
  instr_decode u_head_dec  (.instr_i(sb_head_instr), .dec_o(head_dec));

  assign unused_dec = ^{fetch_dec.is_multi, fetch_dec.is_branch,
                        head_dec.rd, head_dec.rs1, head_dec.rs2};

  logic live, shadow, flush_now, head_valid, can_issue, md_idle;
  logic issue_md, issue_alu, md_result, md_grant;

  assign live       = !reset;
  assign shadow     = alu_v_q && alu_is_br_q;
  assign flush_now  = live && shadow && alu_redirect;
  assign head_valid = sb_head_ready && (sb_head_instr != '0) && !sb_is_empty;
  // The branch shadow also covers the flush cycle, so one term blocks both.
  assign can_issue  = live && head_valid && !shadow;
  assign md_idle    = (md_state_q == MD_IDLE);
  assign issue_md   = can_issue && head_dec.is_multi && md_idle;
  assign issue_alu  = can_issue && !head_dec.is_multi &&
                      (!head_dec.is_branch || (md_idle && !alu_v_q));

  // ALU completions always win; a ready mult/div result waits for a free slot.
  assign md_result  = (md_state_q == MD_HOLD) || ((md_state_q == MD_BUSY) && md_done);
  assign md_grant   = live && md_result && !alu_v_q;

  assign sb_push     = live && fetch_valid && !sb_is_full && !flush_now;
  assign fetch_ready = sb_push;
  assign sb_instr    = sb_push ? fetch_instr : '0;
  assign sb_pc       = sb_push ? fetch_pc : '0;
  assign sb_rd       = sb_push ? fetch_dec.rd : '0;
  assign sb_rs1      = sb_push ? fetch_dec.rs1 : '0;
  assign sb_rs2      = sb_push ? fetch_dec.rs2 : '0;

  assign sb_start_head = issue_alu || issue_md;
  assign alu_issue     = issue_alu;
  assign alu_instr     = issue_alu ? sb_head_instr : '0;
  assign alu_pc        = issue_alu ? sb_head_pc : '0;
  assign md_start      = issue_md;
  assign md_instr      = issue_md ? sb_head_instr : md_instr_q;
  assign md_ack        = md_grant;

  assign sb_commit          = (live && alu_v_q) || md_grant;
  assign sb_instr_to_finish = (live && alu_v_q) ? alu_instr_q :
                              md_grant          ? md_instr_q  : '0;
  assign sb_flush           = flush_now;
  assign sb_instr_to_flush  = flush_now ? alu_instr_q : '0;
  assign redirect           = flush_now;

  always_comb begin
    alu_v_d     = issue_alu;
    alu_is_br_d = issue_alu && head_dec.is_branch;
    alu_instr_d = issue_alu ? sb_head_instr : '0;
    md_state_d  = md_state_q;
    md_instr_d  = md_instr_q;
    case (md_state_q)
      MD_IDLE: if (issue_md) begin
        md_state_d = MD_BUSY;
        md_instr_d = sb_head_instr;
      end
      MD_BUSY: if (md_done) begin
        md_state_d = md_grant ? MD_IDLE : MD_HOLD;
        if (md_grant) md_instr_d = '0;
      end
      MD_HOLD: if (md_grant) begin
        md_state_d = MD_IDLE;
        md_instr_d = '0;
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_v_q     <= 1'b0;
      alu_is_br_q <= 1'b0;
      alu_instr_q <= '0;
      md_state_q  <= MD_IDLE;
      md_instr_q  <= '0;
    end else begin
      alu_v_q     <= alu_v_d;
      alu_is_br_q <= alu_is_br_d;
      alu_instr_q <= alu_instr_d;
      md_state_q  <= md_state_d;
      md_instr_q  <= md_instr_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Directed, table-driven bench for scoreboard_issue_ctrl plus a hand-written reset sequence.
module tb_scoreboard_issue_ctrl;
  localparam int W = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         fetch_valid;
  logic [W-1:0] fetch_instr, fetch_pc;
  logic         fetch_ready, sb_push;
  logic [W-1:0] sb_instr, sb_pc;
  logic [4:0]   sb_rd, sb_rs1, sb_rs2;
  logic         sb_is_full, sb_is_empty;
  logic [W-1:0] sb_head_instr, sb_head_pc;
  logic         sb_head_ready, sb_start_head, sb_commit;
  logic [W-1:0] sb_instr_to_finish;
  logic         sb_flush;
  logic [W-1:0] sb_instr_to_flush;
  logic         alu_issue;
  logic [W-1:0] alu_instr, alu_pc;
  logic         alu_redirect, md_start;
  logic [W-1:0] md_instr;
  logic         md_done, md_ack, redirect;

  scoreboard_issue_ctrl #(.SB_SIZE(32), .W(W)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .sb_push(sb_push), .sb_instr(sb_instr), .sb_pc(sb_pc),
    .sb_rd(sb_rd), .sb_rs1(sb_rs1), .sb_rs2(sb_rs2),
    .sb_is_full(sb_is_full), .sb_is_empty(sb_is_empty),
    .sb_head_instr(sb_head_instr), .sb_head_pc(sb_head_pc), .sb_head_ready(sb_head_ready),
    .sb_start_head(sb_start_head), .sb_commit(sb_commit), .sb_instr_to_finish(sb_instr_to_finish),
    .sb_flush(sb_flush), .sb_instr_to_flush(sb_instr_to_flush),
    .alu_issue(alu_issue), .alu_instr(alu_instr), .alu_pc(alu_pc), .alu_redirect(alu_redirect),
    .md_start(md_start), .md_instr(md_instr), .md_done(md_done), .md_ack(md_ack),
    .redirect(redirect)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] aluop, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [4:0] op, input logic [26:0] tgt);
    return {op, tgt};
  endfunction

  function automatic logic [31:0] pc_of(input logic [31:0] instr);
    return {16'h0040, instr[15:0]} + 32'd4;
  endfunction

  typedef struct {
    logic        fv;
    logic [31:0] fi;
    logic        full;
    logic [31:0] hi;
    logic        hr, rdr, mdone;
    logic        e_push;
    logic [14:0] e_regs;
    logic        e_alu, e_md, e_commit;
    logic [31:0] e_fin;
    logic        e_flush, e_ack;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic fv, input logic [31:0] fi, input logic full,
                         input logic [31:0] hi, input logic hr, input logic rdr, input logic mdone,
                         input logic e_push, input logic [14:0] e_regs,
                         input logic e_alu, input logic e_md, input logic e_commit,
                         input logic [31:0] e_fin, input logic e_flush, input logic e_ack);
    vec_t v;
    v.fv = fv; v.fi = fi; v.full = full; v.hi = hi; v.hr = hr; v.rdr = rdr; v.mdone = mdone;
    v.e_push = e_push; v.e_regs = e_regs; v.e_alu = e_alu; v.e_md = e_md;
    v.e_commit = e_commit; v.e_fin = e_fin; v.e_flush = e_flush; v.e_ack = e_ack;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic fv, input logic [31:0] fi, input logic full,
                       input logic [31:0] hi, input logic hr, input logic rdr, input logic mdone);
    fetch_valid   = fv;
    fetch_instr   = fi;
    fetch_pc      = pc_of(fi);
    sb_is_full    = full;
    sb_head_instr = hi;
    sb_head_pc    = pc_of(hi);
    sb_is_empty   = (hi == 32'd0);
    sb_head_ready = hr;
    alu_redirect  = rdr;
    md_done       = mdone;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    chk("fetch_ready", idx, fetch_ready, v.e_push);
    chk("sb_push", idx, sb_push, v.e_push);
    if (v.e_push) begin
      chk("sb_regs", idx, {sb_rd, sb_rs1, sb_rs2}, v.e_regs);
      chk("sb_instr", idx, sb_instr, v.fi);
      chk("sb_pc", idx, sb_pc, pc_of(v.fi));
    end
    chk("sb_start_head", idx, sb_start_head, v.e_alu | v.e_md);
    chk("alu_issue", idx, alu_issue, v.e_alu);
    chk("md_start", idx, md_start, v.e_md);
    if (v.e_alu) begin
      chk("alu_instr", idx, alu_instr, v.hi);
      chk("alu_pc", idx, alu_pc, pc_of(v.hi));
    end
    if (v.e_md) chk("md_instr", idx, md_instr, v.hi);
    chk("sb_commit", idx, sb_commit, v.e_commit);
    if (v.e_commit) chk("sb_instr_to_finish", idx, sb_instr_to_finish, v.e_fin);
    chk("sb_flush", idx, sb_flush, v.e_flush);
    chk("redirect", idx, redirect, v.e_flush);
    if (v.e_flush) chk("sb_instr_to_flush", idx, sb_instr_to_flush, v.e_fin);
    chk("md_ack", idx, md_ack, v.e_ack);
  endtask

  logic [31:0] ADD3, ADD5, MUL4, MUL8, BNE, LW, SW, ADDI, JAL, SETX, BEX, JR, J, BLT;

  initial begin
    ADD3 = rtype(5'd0, 5'd3, 5'd1, 5'd2);
    ADD5 = rtype(5'd0, 5'd5, 5'd6, 5'd7);
    MUL4 = rtype(5'd6, 5'd4, 5'd1, 5'd2);
    MUL8 = rtype(5'd7, 5'd8, 5'd9, 5'd10);
    BNE  = itype(5'b00010, 5'd1, 5'd2, 17'd8);
    LW   = itype(5'b01000, 5'd7, 5'd2, 17'd4);
    SW   = itype(5'b00111, 5'd7, 5'd2, 17'd4);
    ADDI = itype(5'b00101, 5'd9, 5'd10, 17'd5);
    JAL  = jtype(5'b00011, 27'd100);
    SETX = jtype(5'b10101, 27'd5);
    BEX  = jtype(5'b10110, 27'd7);
    JR   = itype(5'b00100, 5'd9, 5'd0, 17'd0);
    J    = jtype(5'b00001, 27'd64);
    BLT  = itype(5'b00110, 5'd1, 5'd2, 17'd12);

    //      fv fi    full hi    hr rdr mdn | push regs               alu md cmt fin   fl ack
    add_vec(0, 0,    0,   0,    0, 0,  0,    0, 15'd0,               0,  0, 0,  0,    0, 0); // reset state
    add_vec(1, ADD3, 0,   0,    0, 0,  0,    1, {5'd3,5'd1,5'd2},    0,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   ADD3, 1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   0,    0, 0,  0,    0, 15'd0,               0,  0, 1,  ADD3, 0, 0);
    add_vec(1, ADD5, 0,   MUL4, 1, 0,  0,    1, {5'd5,5'd6,5'd7},    0,  1, 0,  0,    0, 0);
    add_vec(0, 0,    0,   ADD5, 1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   0,    0, 0,  1,    0, 15'd0,               0,  0, 1,  ADD5, 0, 0); // collision
    add_vec(0, 0,    0,   0,    0, 0,  1,    0, 15'd0,               0,  0, 1,  MUL4, 0, 1);
    add_vec(0, 0,    0,   0,    0, 0,  0,    0, 15'd0,               0,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   MUL4, 1, 0,  0,    0, 15'd0,               0,  1, 0,  0,    0, 0); // back-to-back mul
    add_vec(0, 0,    0,   MUL8, 1, 0,  0,    0, 15'd0,               0,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   MUL8, 1, 0,  1,    0, 15'd0,               0,  0, 1,  MUL4, 0, 1);
    add_vec(0, 0,    0,   MUL8, 1, 0,  0,    0, 15'd0,               0,  1, 0,  0,    0, 0);
    add_vec(0, 0,    0,   0,    0, 0,  1,    0, 15'd0,               0,  0, 1,  MUL8, 0, 1);
    add_vec(0, 0,    0,   BNE,  1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0); // mispredict
    add_vec(1, ADD5, 0,   ADD3, 1, 1,  0,    0, 15'd0,               0,  0, 1,  BNE,  1, 0);
    add_vec(0, 0,    0,   BNE,  1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0); // shadow, no flush
    add_vec(1, ADD5, 0,   ADD3, 1, 0,  0,    1, {5'd5,5'd6,5'd7},    0,  0, 1,  BNE,  0, 0);
    add_vec(0, 0,    0,   ADD3, 1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   0,    0, 0,  0,    0, 15'd0,               0,  0, 1,  ADD3, 0, 0);
    add_vec(0, 0,    0,   ADD3, 1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0); // branch waits on alu_v
    add_vec(0, 0,    0,   BNE,  1, 0,  0,    0, 15'd0,               0,  0, 1,  ADD3, 0, 0);
    add_vec(0, 0,    0,   BNE,  1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   0,    0, 0,  0,    0, 15'd0,               0,  0, 1,  BNE,  0, 0);
    add_vec(1, ADD3, 1,   0,    0, 0,  0,    0, 15'd0,               0,  0, 0,  0,    0, 0); // full
    add_vec(1, ADD3, 1,   ADD5, 1, 0,  0,    0, 15'd0,               1,  0, 0,  0,    0, 0);
    add_vec(1, ADD3, 1,   0,    0, 0,  0,    0, 15'd0,               0,  0, 1,  ADD5, 0, 0);
    add_vec(1, ADD3, 0,   0,    0, 0,  0,    1, {5'd3,5'd1,5'd2},    0,  0, 0,  0,    0, 0);
    add_vec(1, LW,   0,   0,    0, 0,  0,    1, {5'd7,5'd2,5'd0},    0,  0, 0,  0,    0, 0); // decode
    add_vec(1, SW,   0,   0,    0, 0,  0,    1, {5'd0,5'd7,5'd2},    0,  0, 0,  0,    0, 0);
    add_vec(1, ADDI, 0,   0,    0, 0,  0,    1, {5'd9,5'd10,5'd0},   0,  0, 0,  0,    0, 0);
    add_vec(1, JAL,  0,   0,    0, 0,  0,    1, {5'd31,5'd0,5'd0},   0,  0, 0,  0,    0, 0);
    add_vec(1, SETX, 0,   0,    0, 0,  0,    1, {5'd30,5'd0,5'd0},   0,  0, 0,  0,    0, 0);
    add_vec(1, BEX,  0,   0,    0, 0,  0,    1, {5'd0,5'd30,5'd0},   0,  0, 0,  0,    0, 0);
    add_vec(1, JR,   0,   0,    0, 0,  0,    1, {5'd0,5'd9,5'd0},    0,  0, 0,  0,    0, 0);
    add_vec(1, J,    0,   0,    0, 0,  0,    1, {5'd0,5'd0,5'd0},    0,  0, 0,  0,    0, 0);
    add_vec(1, BLT,  0,   0,    0, 0,  0,    1, {5'd0,5'd1,5'd2},    0,  0, 0,  0,    0, 0);
    add_vec(0, 0,    0,   ADD3, 0, 0,  0,    0, 15'd0,               0,  0, 0,  0,    0, 0); // head not ready

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fv, tbl[i].fi, tbl[i].full, tbl[i].hi, tbl[i].hr, tbl[i].rdr, tbl[i].mdone);
      #1;
      check_vec(i, tbl[i]);
      $display("vec %0d push=%b start=%b alu=%b md=%b commit=%b fin=%h flush=%b ack=%b",
               i, sb_push, sb_start_head, alu_issue, md_start, sb_commit,
               sb_instr_to_finish, sb_flush, md_ack);
      @(negedge clock);
    end

    // Reset while the mult/div unit is busy, then a stale md_done.
    drive(0, 0, 0, MUL4, 1, 0, 0);
    #1 chk("rst_md_start", 100, md_start, 1'b1);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rst_outputs", 101,
        {31'd0, fetch_ready | sb_push | sb_start_head | sb_commit | sb_flush | alu_issue
                | md_start | md_ack | redirect}, 32'd0);
    chk("rst_md_instr", 101, md_instr, 32'd0);
    chk("rst_finish", 101, sb_instr_to_finish, 32'd0);
    $display("rst post cycle commit=%b ack=%b md_instr=%h", sb_commit, md_ack, md_instr);
    @(negedge clock);
    #1;
    chk("stale_done_ack", 102, md_ack, 1'b0);
    chk("stale_done_commit", 102, sb_commit, 1'b0);
    $display("stale md_done commit=%b ack=%b", sb_commit, md_ack);
    @(negedge clock);
    drive(0, 0, 0, MUL8, 1, 0, 0);
    #1;
    chk("post_rst_md_start", 103, md_start, 1'b1);
    chk("post_rst_md_instr", 103, md_instr, MUL8);
    $display("post-reset mul issue md_start=%b md_instr=%h", md_start, md_instr);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("post_rst_commit", 104, sb_commit, 1'b1);
    chk("post_rst_finish", 104, sb_instr_to_finish, MUL8);
    chk("post_rst_ack", 104, md_ack, 1'b1);
    $display("post-reset mul commit=%b fin=%h ack=%b", sb_commit, sb_instr_to_finish, md_ack);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard_issue_ctrl.md
Name: scoreboard_issue_ctrl

Overview:
Sequencer wrapped around the Scoreboard instance. It decodes fetched instructions and pushes them into the scoreboard. It issues the scoreboard head to either the single-cycle ALU pipe or the multicycle mult/div unit, and arbitrates completions onto the scoreboard's single commit port. On a resolved branch redirect it drives the scoreboard flush and squashes fetch for that cycle.

Parameters:
SB_SIZE, 32, scoreboard depth; passed through only, used by no logic here.
W, 32, instruction/PC width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch offers an instruction
fetch_instr  in  W  offered instruction
fetch_pc  in  W  its PC
fetch_ready  out  1  instruction accepted this cycle
sb_push  out  1  to scoreboard push
sb_instr, sb_pc  out  W  to scoreboard instr_in/pc_in
sb_rd, sb_rs1, sb_rs2  out  5  decoded register fields
sb_is_full, sb_is_empty  in  1  scoreboard status
sb_head_instr, sb_head_pc  in  W  scoreboard head
sb_head_ready  in  1  head operands free
sb_start_head  out  1  marks head running
sb_commit  out  1  to committing_instr
sb_instr_to_finish  out  W  instruction being committed
sb_flush  out  1  to flushing_instr
sb_instr_to_flush  out  W  flush key
alu_issue  out  1  ALU issue pulse
alu_instr, alu_pc  out  W  ALU operands
alu_redirect  in  1  ALU-stage branch mispredicted (valid only in the cycle after alu_issue)
md_start  out  1  mult/div start pulse
md_instr  out  W  mult/div instruction
md_done  in  1  mult/div result ready (level; held until md_ack)
md_ack  out  1  mult/div result committed
redirect  out  1  to fetch: discard in-flight fetch

Behaviour:
- Decode (ISA): opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]. R-type writes rd and reads rs/rt. Addi/lw read rs and write rd. Sw/bne/blt read rd,rs with sb_rd=0. j/jal/bex/setx follow the ISA table in the package. Unused fields drive 0.
- Multicycle = opcode 00000 and aluop 00110/00111.
- Branch = bne, blt, j, jal, jr, bex.
- Push: sb_push = fetch_ready = fetch_valid & !sb_is_full & !flush_now. Push is combinational from fetch, with no buffering.
- Issue, evaluated each cycle; head is valid when sb_head_ready and sb_head_instr != 0.
  - Multicycle head: issue only if md_state==MD_IDLE.
  - Branch head: issue only if md_state==MD_IDLE and alu_v==0.
  - Other heads: always issue.
  - Never issue in a flush cycle or in the branch-shadow cycle (alu_v and alu_is_br).
  - On issue, sb_start_head=1 for one cycle, together with alu_issue or md_start.
- ALU pipe: register alu_v/alu_instr/alu_is_br loads on alu_issue. The ALU instruction completes the following cycle.
- md FSM:
  - MD_IDLE -> MD_BUSY on md_start; latches md_instr.
  - MD_BUSY -> MD_HOLD when md_done.
  - MD_HOLD -> MD_IDLE on commit grant (md_ack=1 that cycle).
  - Commit from MD_BUSY is allowed in the same cycle md_done rises if granted.
- Commit arbiter, one commit per cycle; ALU completion has priority. The ALU stage always commits in its completion cycle. The MD result waits in MD_HOLD. sb_instr_to_finish is the granted instruction.
- Flush: flush_now = alu_v & alu_is_br & alu_redirect. In that cycle:
  - sb_commit=1 for the branch.
  - sb_flush=1 with sb_instr_to_flush=alu_instr, which removes all younger entries.
  - redirect=1; no push, no issue.
  - The MD unit is idle by construction.
- Reset: all outputs 0, alu_v=0, md_state=MD_IDLE. Reset while MD_BUSY abandons the op; md_ack is not asserted.
- Latency: fetch->scoreboard 0 cycles. Issue->ALU commit 1 cycle. MD commit is the md_done cycle, or later if it collides with an ALU commit.
- sb_is_full: fetch stalls with fetch_ready=0 and instruction fields held by fetch.
- sb_is_empty: no issue is attempted.

Decomposition:
- Package scoreboard_pkg:
  - opcode/aluop constants
  - instruction field bit positions
  - md_state enum {MD_IDLE, MD_BUSY, MD_HOLD}
  - decode result struct {rd, rs1, rs2, is_multi, is_branch}
- Sub-module instr_decode: combinational field extraction. It is instantiated twice, once for fetch and once for head classification.

Test Plan:
- Push add r3,r1,r2 into an empty scoreboard -> same cycle sb_push=1, sb_rd=3, sb_rs1=1, sb_rs2=2. Next cycle sb_start_head=1 and alu_issue=1. One cycle later sb_commit=1 with sb_instr_to_finish=that add.
- mul r4,r1,r2 then add r5,r6,r7 -> md_start on mul and the add issues next. md_done arrives in the same cycle as the add's ALU completion -> add commits first, md_state=MD_HOLD, mul commits the following cycle with md_ack=1.
- Two back-to-back mul with independent regs -> second is not issued until md_state returns to MD_IDLE.
- bne issued with alu_redirect=1 -> in one cycle sb_commit=1, sb_flush=1, sb_instr_to_flush=bne, redirect=1, fetch_ready=0. No start in the shadow cycle.
- Fill to sb_is_full=1 with fetch_valid held -> fetch_ready=0 until one commit frees a slot.
- Assert reset during MD_BUSY -> next cycle all outputs 0 and md_state=MD_IDLE. A stale md_done afterward is ignored.
